// File: rtl/cam_src_pkg.sv
// -----------------------------------------------------------------------------
// cam_src_pkg
// Shared constants for the camera-timing stimulus source:
//   - FSM state encodings (IDLE, VSYNC, VBACK, ACTIVE, BLANK, FEND)
//   - pattern mode encodings (MODE_MEM, MODE_RAMP, MODE_FRAME, MODE_CHECK)
//   - LINE_BYTES for the default geometry, and helpers used to derive the
//     per-instance geometry constants.
// -----------------------------------------------------------------------------
package cam_src_pkg;

  // FSM states, kept as plain constants so the encoding stays fixed.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_BLANK  = 3'd4;
  localparam logic [2:0] ST_FEND   = 3'd5;

  // Byte pattern selection, sampled at start.
  localparam logic [1:0] MODE_MEM   = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_FRAME = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  // Default geometry: bytes per line = active pixels * bytes per pixel.
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_BPP      = 2;
  localparam int LINE_BYTES   = DEF_H_ACTIVE * DEF_BPP;

  // Bytes per line for an arbitrary parameterisation.
  function automatic int line_bytes(input int h_active, input int bpp);
    return h_active * bpp;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cam_src_if.sv
// -----------------------------------------------------------------------------
// cam_src_if
// Camera-side bus of the frame source: the external store read port and the
// sensor-style output stream.
//   mem_addr     byte read address into the external store
//   mem_rd_data  store data, valid one cycle after mem_addr
//   vsync        frame sync, active high
//   href         line valid, active high
//   camera_data  byte qualified by href
// master = the frame source, slave = the store / the image consumer.
// -----------------------------------------------------------------------------
interface cam_src_if #(
  parameter int AW = 18
);
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          vsync;
  logic          href;
  logic [7:0]    camera_data;

  modport master (
    output mem_addr, vsync, href, camera_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr, vsync, href, camera_data,
    output mem_rd_data
  );
endinterface

// File: rtl/cam_src_pattern.sv
// -----------------------------------------------------------------------------
// cam_src_pattern
// Stage-1 byte mux of the frame source. Built-in patterns are computed from
// the stage-0 position and registered; memory mode passes the store's read
// data straight through, because the store itself provides the stage-1
// register (its data arrives one cycle after the stage-0 address).
// Ports:
//   pclk, rst     clock, synchronous active-high reset
//   href_i        stage-0 line valid
//   mode          pattern select (run-constant)
//   h             low byte of the byte index within the line
//   line3         bit 3 of the line index (checker pattern)
//   frame_idx     index of the frame being emitted
//   mem_rd_data   store read data
//   href_s1       stage-1 (output) line valid, gates camera_data
//   camera_data   output byte, 0 whenever href_s1 is low
// -----------------------------------------------------------------------------
module cam_src_pattern
  import cam_src_pkg::*;
#(
  parameter int FCW = 4
) (
  input  logic           pclk,
  input  logic           rst,
  input  logic           href_i,
  input  logic [1:0]     mode,
  input  logic [7:0]     h,
  input  logic           line3,
  input  logic [FCW-1:0] frame_idx,
  input  logic [7:0]     mem_rd_data,
  input  logic           href_s1,
  output logic [7:0]     camera_data
);

  // frame_idx zero-extended or truncated to one byte.
  localparam int NB = (FCW < 8) ? FCW : 8;

  logic [7:0] pat_d, pat_q;
  logic       mem_sel_d, mem_sel_q;

  always_comb begin
    pat_d     = 8'h00;
    mem_sel_d = (mode == MODE_MEM);
    case (mode)
      MODE_RAMP:  pat_d = h;
      MODE_FRAME: pat_d = 8'(frame_idx[NB-1:0]);
      MODE_CHECK: pat_d = (h[3] ^ line3) ? 8'hFF : 8'h00;
      default:    pat_d = 8'h00;
    endcase
    if (!href_i) pat_d = 8'h00;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pat_q     <= 8'h00;
      mem_sel_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      mem_sel_q <= mem_sel_d;
    end
  end

  assign camera_data = !href_s1 ? 8'h00 : (mem_sel_q ? mem_rd_data : pat_q);

endmodule

// File: rtl/cam_frame_source.sv
// -----------------------------------------------------------------------------
// cam_frame_source
// Synthesizable camera-timing stimulus source. Generates vsync / href and an
// 8-bit byte stream with configurable geometry, blanking and frame count;
// bytes come from an external 1-cycle-latency store or built-in patterns.
// Ports:
//   pclk        the only clock
//   rst         synchronous reset, active high; aborts a run immediately
//   start       one-cycle pulse starting a run (ignored while busy)
//   stop        one-cycle pulse; the current frame completes, then idle
//   mode        0=memory 1=ramp 2=frame-constant 3=checker (sampled at start)
//   num_frames  frames per run, 0 = continuous (sampled at start)
//   cam         master side of cam_src_if (store port + vsync/href/data)
//   frame_idx   index of the frame being emitted, wraps mod 2^FCW
//   busy        high from the cycle after start until done
//   done        one-cycle pulse at run end
// Optional (macro CAM_SRC_CHECKSUM_EN):
//   frame_sum   16-bit wrapping sum of the href-qualified bytes of a frame
//   sum_valid   pulse one cycle after the last href of the frame
// Timing: stage 0 is the FSM and address; vsync/href/camera_data are stage 1,
// one cycle later. done/busy/frame_idx are stage-0 registered outputs.
// -----------------------------------------------------------------------------
module cam_frame_source
  import cam_src_pkg::*;
#(
  parameter int H_ACTIVE  = 1280,
  parameter int BPP       = 2,
  parameter int V_ACTIVE  = 56,
  parameter int H_BLANK   = 32,
  parameter int VS_LEN    = 50,
  parameter int VB_LEN    = 50,
  parameter int MEM_DEPTH = 143360,
  parameter int AW        = 18,
  parameter int FCW       = 4
) (
  input  logic           pclk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic [1:0]     mode,
  input  logic [FCW-1:0] num_frames,
  cam_src_if.master      cam,
  output logic [FCW-1:0] frame_idx,
  output logic           busy,
  output logic           done
`ifdef CAM_SRC_CHECKSUM_EN
  ,
  output logic [15:0]    frame_sum,
  output logic           sum_valid
`endif
);

  localparam int LB      = line_bytes(H_ACTIVE, BPP);
  localparam int MAX_LEN = max_int(max_int(LB, H_BLANK), max_int(VS_LEN, VB_LEN));
  // At least 8 bits so the low byte of h is always available to the pattern.
  localparam int CW      = max_int(8, $clog2(MAX_LEN));
  // At least 4 bits so line[3] exists for the checker pattern.
  localparam int LW      = max_int(4, $clog2(V_ACTIVE));

  logic [2:0]     state_d, state_q;
  logic [CW-1:0]  cnt_d, cnt_q;          // cycles spent in the current state; h in ACTIVE
  logic [LW-1:0]  line_d, line_q;
  logic [FCW-1:0] frame_idx_d, frame_idx_q;
  logic [1:0]     mode_d, mode_q;
  logic [FCW-1:0] num_frames_d, num_frames_q;
  logic           stop_flag_d, stop_flag_q;
  logic [AW-1:0]  mem_addr_d, mem_addr_q;
  logic           busy_d, busy_q;
  logic           done_d, done_q;
  logic           href_d, href_q;
  logic           vsync_d, vsync_q;
  logic           last_frame;
  logic [7:0]     cam_data;

  // ---------------------------------------------------------------------------
  // Stage 0: frame/line FSM and store address
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    line_d       = line_q;
    frame_idx_d  = frame_idx_q;
    mode_d       = mode_q;
    num_frames_d = num_frames_q;
    stop_flag_d  = stop_flag_q | (stop & (state_q != ST_IDLE));
    last_frame   = (num_frames_q != '0) && ((frame_idx_q + FCW'(1)) == num_frames_q);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          // start wins over a simultaneous stop: the flag starts clear.
          state_d      = ST_VSYNC;
          frame_idx_d  = '0;
          mode_d       = mode;
          num_frames_d = num_frames;
          stop_flag_d  = 1'b0;
        end
      end
      ST_VSYNC: begin
        if (cnt_q == CW'(VS_LEN - 1)) begin
          state_d = ST_VBACK;
          cnt_d   = '0;
        end
      end
      ST_VBACK: begin
        if (cnt_q == CW'(VB_LEN - 1)) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          line_d  = '0;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q == CW'(LB - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end
      ST_BLANK: begin
        if (cnt_q == CW'(H_BLANK - 1)) begin
          cnt_d = '0;
          if (line_q == LW'(V_ACTIVE - 1)) begin
            state_d = ST_FEND;
          end else begin
            state_d = ST_ACTIVE;
            line_d  = line_q + LW'(1);
          end
        end
      end
      ST_FEND: begin
        cnt_d = '0;
        // A stop arriving in this very cycle still ends the run here.
        if (stop_flag_q || stop || last_frame) begin
          state_d = ST_IDLE;
        end else begin
          state_d     = ST_VSYNC;
          frame_idx_d = frame_idx_q + FCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // The byte index runs continuously across the lines of a frame, so the
    // address just steps by one (wrapping at MEM_DEPTH) on every ACTIVE byte
    // and restarts at 0 on the first line. It is registered against the
    // stage-0 byte it addresses and holds its value outside ACTIVE.
    mem_addr_d = mem_addr_q;
    if (state_d == ST_ACTIVE) begin
      if (state_q == ST_VBACK)                      mem_addr_d = '0;
      else if (mem_addr_q == AW'(MEM_DEPTH - 1))    mem_addr_d = '0;
      else                                          mem_addr_d = mem_addr_q + AW'(1);
    end

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_FEND) && (state_d == ST_IDLE);

    // Stage-1 sync outputs follow the stage-0 state by one cycle.
    href_d  = (state_q == ST_ACTIVE);
    vsync_d = (state_q == ST_VSYNC);
  end

  always_ff @(posedge pclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      frame_idx_q  <= '0;
      mode_q       <= MODE_MEM;
      num_frames_q <= '0;
      stop_flag_q  <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      frame_idx_q  <= frame_idx_d;
      mode_q       <= mode_d;
      num_frames_q <= num_frames_d;
      stop_flag_q  <= stop_flag_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      href_q       <= href_d;
      vsync_q      <= vsync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: byte mux
  // ---------------------------------------------------------------------------
  cam_src_pattern #(
    .FCW (FCW)
  ) u_pattern (
    .pclk        (pclk),
    .rst         (rst),
    .href_i      (state_q == ST_ACTIVE),
    .mode        (mode_q),
    .h           (cnt_q[7:0]),
    .line3       (line_q[3]),
    .frame_idx   (frame_idx_q),
    .mem_rd_data (cam.mem_rd_data),
    .href_s1     (href_q),
    .camera_data (cam_data)
  );

  assign cam.mem_addr    = mem_addr_q;
  assign cam.vsync       = vsync_q;
  assign cam.href        = href_q;
  assign cam.camera_data = cam_data;
  assign frame_idx       = frame_idx_q;
  assign busy            = busy_q;
  assign done            = done_q;

`ifdef CAM_SRC_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Per-frame checksum of the emitted bytes
  // ---------------------------------------------------------------------------
  logic        last_d, last_q;           // stage-1 marker of the frame's last byte
  logic [15:0] acc_d, acc_q;
  logic [15:0] frame_sum_d, frame_sum_q;
  logic        sum_valid_d, sum_valid_q;

  always_comb begin
    last_d      = (state_q == ST_ACTIVE) && (cnt_q == CW'(LB - 1)) &&
                  (line_q == LW'(V_ACTIVE - 1));
    acc_d       = acc_q;
    frame_sum_d = frame_sum_q;
    sum_valid_d = 1'b0;
    if ((state_d == ST_VSYNC) && (state_q != ST_VSYNC)) begin
      acc_d = '0;
    end else if (href_q) begin
      acc_d = acc_q + {8'h00, cam_data};
    end
    // The last byte is folded in directly so the sum is ready one cycle later.
    if (href_q && last_q) begin
      frame_sum_d = acc_q + {8'h00, cam_data};
      sum_valid_d = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      last_q      <= 1'b0;
      acc_q       <= '0;
      frame_sum_q <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      acc_q       <= acc_d;
      frame_sum_q <= frame_sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign frame_sum = frame_sum_q;
  assign sum_valid = sum_valid_q;
`endif

endmodule

// File: tb/tb_cam_frame_source.sv
// -----------------------------------------------------------------------------
// tb_cam_frame_source
// Scoreboard bench for cam_frame_source. Each run pushes its expected output
// events (vsync cycles, href bytes with their cycle stamps, done, checksum)
// computed from frame geometry arithmetic; a monitor pops and compares them
// whenever the DUT presents the matching output.
// -----------------------------------------------------------------------------
module tb_cam_frame_source;

  localparam int H_ACTIVE  = 4;
  localparam int BPP       = 2;
  localparam int V_ACTIVE  = 3;
  localparam int H_BLANK   = 2;
  localparam int VS_LEN    = 2;
  localparam int VB_LEN    = 3;
  localparam int MEM_DEPTH = 16;
  localparam int AW        = 4;
  localparam int FCW       = 4;

  localparam int LB   = H_ACTIVE * BPP;
  localparam int LP   = LB + H_BLANK;                      // line period
  localparam int FCYC = VS_LEN + VB_LEN + V_ACTIVE * LP + 1; // cycles per frame

  logic           pclk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic [FCW-1:0] num_frames = '0;
  logic [FCW-1:0] frame_idx;
  logic           busy;
  logic           done;
`ifdef CAM_SRC_CHECKSUM_EN
  logic [15:0]    frame_sum;
  logic           sum_valid;
`endif

  cam_src_if #(.AW(AW)) cam_bus ();

  cam_frame_source #(
    .H_ACTIVE (H_ACTIVE), .BPP (BPP), .V_ACTIVE (V_ACTIVE), .H_BLANK (H_BLANK),
    .VS_LEN (VS_LEN), .VB_LEN (VB_LEN), .MEM_DEPTH (MEM_DEPTH), .AW (AW), .FCW (FCW)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .num_frames (num_frames),
    .cam        (cam_bus),
    .frame_idx  (frame_idx),
    .busy       (busy),
    .done       (done)
`ifdef CAM_SRC_CHECKSUM_EN
    ,
    .frame_sum  (frame_sum),
    .sum_valid  (sum_valid)
`endif
  );

  always #5 pclk = ~pclk;

  // External store: 1-cycle read latency.
  logic [7:0] mem [MEM_DEPTH];
  always @(posedge pclk) cam_bus.mem_rd_data <= mem[cam_bus.mem_addr];

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t byte_q[$];
  exp_t vs_q[$];
  exp_t done_q[$];
  exp_t sum_q[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: output event at cycle %0d with nothing expected", name, cyc);
  endtask

  // Reference byte for frame k, line l, byte h of the line.
  function automatic int ref_byte(input int md, input int k, input int l, input int h);
    case (md)
      0:       return int'(mem[(l * LB + h) % MEM_DEPTH]);
      1:       return h % 256;
      2:       return k % (1 << FCW);
      default: return ((((h / 8) % 2) ^ ((l / 8) % 2)) != 0) ? 255 : 0;
    endcase
  endfunction

  // Expected output events for a run of nk frames whose start pulse is high
  // during cycle c0. Outputs trail the state machine by one cycle, which
  // itself enters VSYNC one cycle after start.
  task automatic expect_run(input int c0, input int md, input int nk);
    for (int k = 0; k < nk; k++) begin
      int base;
      int sum;
      for (int i = 0; i < VS_LEN; i++) vs_q.push_back('{cyc: c0 + 2 + k * FCYC + i, val: 1});
      base = c0 + 2 + k * FCYC + VS_LEN + VB_LEN;
      sum  = 0;
      for (int l = 0; l < V_ACTIVE; l++) begin
        for (int h = 0; h < LB; h++) begin
          int v;
          v = ref_byte(md, k, l, h);
          sum += v;
          byte_q.push_back('{cyc: base + l * LP + h, val: v});
        end
      end
`ifdef CAM_SRC_CHECKSUM_EN
      sum_q.push_back('{cyc: base + (V_ACTIVE - 1) * LP + LB, val: sum % 65536});
`endif
    end
    done_q.push_back('{cyc: c0 + nk * FCYC + 1, val: 1});
  endtask

  task automatic flush_queues();
    byte_q.delete();
    vs_q.delete();
    done_q.delete();
    sum_q.delete();
  endtask

  // One run. stop_off / busy_start_off are cycle offsets after start (0 = none);
  // both = stop pulsed together with start.
  task automatic run(input int md, input int nf, input int stop_off, input bit both,
                     input int busy_start_off);
    int nk;
    int c0;
    bit seen;
    nk = nf;
    if (stop_off > 0) begin
      int ks;
      ks = (stop_off - 1) / FCYC + 1;
      if (nf == 0 || ks < nk) nk = ks;
    end
    @(posedge pclk); #1;
    c0 = cyc;
    expect_run(c0, md, nk);
    mode       = 2'(md);
    num_frames = FCW'(nf);
    start      = 1'b1;
    stop       = both;
    seen       = 1'b0;
    for (int n = 1; n <= nk * FCYC + 10; n++) begin
      @(posedge pclk); #1;
      start = (busy_start_off != 0) && (n == busy_start_off) && (n <= nk * FCYC);
      stop  = (stop_off != 0) && (n == stop_off);
      if (n == 1) check("busy_after_start", busy, 1);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    check("done_seen", seen, 1);
    check("frame_idx_end", frame_idx, (nk - 1) % (1 << FCW));
    check("busy_end", busy, 0);
    repeat (6) @(posedge pclk);
    #1;
    check("bytes_left", byte_q.size(), 0);
    check("vsync_left", vs_q.size(), 0);
    check("done_left", done_q.size(), 0);
`ifdef CAM_SRC_CHECKSUM_EN
    check("sum_left", sum_q.size(), 0);
`endif
    flush_queues();
  endtask

  // Monitor: compare each presented output against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge pclk);
      if (!rst) begin
        if (cam_bus.href) begin
          if (byte_q.size() == 0) unexpected("href_unexpected");
          else begin
            e = byte_q.pop_front();
            check("href_cycle", cyc, e.cyc);
            check("pixel_byte", cam_bus.camera_data, e.val);
          end
        end else begin
          check("data_gated", cam_bus.camera_data, 0);
        end
        if (cam_bus.vsync) begin
          if (vs_q.size() == 0) unexpected("vsync_unexpected");
          else begin
            e = vs_q.pop_front();
            check("vsync_cycle", cyc, e.cyc);
          end
        end
        if (done) begin
          if (done_q.size() == 0) unexpected("done_unexpected");
          else begin
            e = done_q.pop_front();
            check("done_cycle", cyc, e.cyc);
          end
        end
`ifdef CAM_SRC_CHECKSUM_EN
        if (sum_valid) begin
          if (sum_q.size() == 0) unexpected("sum_unexpected");
          else begin
            e = sum_q.pop_front();
            check("sum_cycle", cyc, e.cyc);
            check("frame_sum", frame_sum, e.val);
          end
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'(i);

    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    @(negedge pclk);
    check("rst_vsync", cam_bus.vsync, 0);
    check("rst_href", cam_bus.href, 0);
    check("rst_data", cam_bus.camera_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_idx", frame_idx, 0);
    check("rst_mem_addr", cam_bus.mem_addr, 0);

    // Ramp, two frames.
    run(1, 2, 0, 1'b0, 0);
    // Memory playback with address wrap.
    run(0, 1, 0, 1'b0, 0);
    // Continuous, stop mid-line 1 of frame 2.
    run(0, 0, 2 * FCYC + 1 + VS_LEN + VB_LEN + LP + 3, 1'b0, 0);

    // Reset during ACTIVE aborts at once.
    begin
      int c0;
      @(posedge pclk); #1;
      c0 = cyc;
      expect_run(c0, 1, 1);
      mode = 2'd1; num_frames = FCW'(0); start = 1'b1;
      @(posedge pclk); #1;
      start = 1'b0;
      while (cyc < c0 + 1 + VS_LEN + VB_LEN + LP + 3) begin
        @(posedge pclk); #1;
      end
      rst = 1'b1;
      flush_queues();
      @(posedge pclk); #1;
      rst = 1'b0;
      @(negedge pclk);
      check("abort_href", cam_bus.href, 0);
      check("abort_vsync", cam_bus.vsync, 0);
      check("abort_data", cam_bus.camera_data, 0);
      check("abort_busy", busy, 0);
      check("abort_frame_idx", frame_idx, 0);
    end
    run(1, 1, 0, 1'b0, 0);

    // Checker (all zero at this size), with a start while busy.
    run(3, 3, 0, 1'b0, 50);
    // stop in IDLE is ignored.
    @(posedge pclk); #1 stop = 1'b1;
    @(posedge pclk); #1 stop = 1'b0;
    run(2, 3, 0, 1'b0, 40);
    // start and stop together in IDLE: start wins.
    run(1, 2, 0, 1'b1, 0);

    // Randomised runs with random store contents.
    for (int it = 0; it < 6; it++) begin
      int md;
      int nf;
      int so;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
      md = int'($urandom_range(0, 3));
      nf = int'($urandom_range(0, 3));
      if (nf == 0) so = int'($urandom_range(2, 3 * FCYC));
      else if ($urandom_range(0, 1) == 1) so = int'($urandom_range(2, nf * FCYC));
      else so = 0;
      run(md, nf, so, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
